// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package seg_pkg;

    localparam int unsigned SEG_MAX_DIGITS = 8;
    localparam int unsigned SEG_IDX_W      = 3;

    typedef logic [SEG_IDX_W-1:0] seg_idx_t;

    // Active-low all-segments-off pattern for the integrating top.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg_scan_if.sv
// Valid/ready load port carrying a packed multi-digit hex value into seg_scan.
interface seg_scan_if
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = SEG_MAX_DIGITS
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seg_scan_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks, counter cleared on rst.
module seg_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;

    always_comb begin
        pre_nxt = pre + PW'(1);
        if (pre == LAST) begin
            pre_nxt = '0;
        end
    end

    // tick is registered from the next count, so it is high exactly while pre == DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre  <= '0;
            tick <= (DIV == 1);
        end else begin
            pre  <= pre_nxt;
            tick <= (pre_nxt == LAST);
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed display scanner with frame-aligned commit of a shadowed value.
// Optional leading-zero blanking when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = SEG_MAX_DIGITS,
    parameter int unsigned DIV    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_if.slave         bus,
    output logic [3:0]        nibble,
    output logic [DIGITS-1:0] dig_en_n,
    output logic              blank
);

    localparam int unsigned DW       = 4 * DIGITS;
    localparam seg_idx_t    LAST_IDX = seg_idx_t'(DIGITS - 1);

    logic [DW-1:0]     disp;
    logic [DW-1:0]     shadow;
    logic              pending;
    logic              pending_nxt;
    seg_idx_t          idx;
    logic              tick;
    logic              wrap_c;
    logic              accept_c;
    logic [DIGITS-1:0] lead_zero;
    logic [3:0]        nib_c;
    logic [DIGITS-1:0] en_c;
    logic              blank_c;

    seg_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap_c   = tick && (idx == LAST_IDX);
    assign accept_c = bus.in_valid && bus.in_ready;

    // Accept only while empty, so an accept never collides with a commit.
    always_comb begin
        pending_nxt = pending;
        if (wrap_c && pending) begin
            pending_nxt = 1'b0;
        end
        if (accept_c) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            disp         <= '0;
            pending      <= 1'b0;
            bus.in_ready <= 1'b1;
        end else begin
            if (accept_c) begin
                shadow <= bus.in_data;
            end
            if (wrap_c && pending) begin
                disp <= shadow;
            end
            pending      <= pending_nxt;
            bus.in_ready <= !pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + seg_idx_t'(1);
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Digit i > 0 is blanked while it and every more-significant digit are zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_run     = zero_run && (disp[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end
`else
    assign lead_zero = '0;
`endif

    always_comb begin
        nib_c   = '0;
        en_c    = '1;
        blank_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == seg_idx_t'(i)) begin
                nib_c   = disp[4*i +: 4];
                blank_c = lead_zero[i];
                en_c[i] = lead_zero[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nibble   <= '0;
            dig_en_n <= '1;
            blank    <= 1'b1;
        end else begin
            nibble   <= nib_c;
            dig_en_n <= en_c;
            blank    <= blank_c;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: a 4-digit/DIV=4 instance and a 1-digit/DIV=1 instance.
module tb_seg_scan;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] nib_a, nib_b;
    logic [3:0] en_a;
    logic [0:0] en_b;
    logic       blank_a, blank_b;

    int errors = 0;
    int checks = 0;

    seg_scan_if #(.DIGITS(4)) bus_a ();
    seg_scan_if #(.DIGITS(1)) bus_b ();

    seg_scan #(.DIGITS(4), .DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a),
        .nibble(nib_a), .dig_en_n(en_a), .blank(blank_a)
    );

    seg_scan #(.DIGITS(1), .DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .nibble(nib_b), .dig_en_n(en_b), .blank(blank_b)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] exp_en(input int s, input logic blk);
        logic [3:0] one;
        one = 4'b0001;
        return blk ? 4'b1111 : ~(one << s);
    endfunction

    // Reset values, then one frame of slot rotation with disp = 0.
    task automatic test_reset();
        logic [3:0] blk;
        int s;
        blk = LZ ? 4'b1110 : 4'b0000;
        step(2);
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus_a.in_ready); end
        checks++; if (en_a !== 4'b1111) begin errors++; $display("FAIL reset_en got=%b exp=1111", en_a); end
        checks++; if (blank_a !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank_a); end
        checks++; if (nib_a !== 4'h0) begin errors++; $display("FAIL reset_nibble got=%h exp=0", nib_a); end
        rst_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            s = k / 4;
            checks++; if (en_a !== exp_en(s, blk[s])) begin errors++; $display("FAIL scan_en k=%0d got=%b exp=%b", k, en_a, exp_en(s, blk[s])); end
            checks++; if (nib_a !== 4'h0) begin errors++; $display("FAIL scan_nibble k=%0d got=%h exp=0", k, nib_a); end
            checks++; if (blank_a !== blk[s]) begin errors++; $display("FAIL scan_blank k=%0d got=%b exp=%b", k, blank_a, blk[s]); end
        end
    endtask

    // Mid-frame accept of 12AF; commit at the next wrap, then one frame of F,A,2,1.
    task automatic test_data();
        logic [3:0] exp_nib [4];
        int s;
        exp_nib = '{4'hF, 4'hA, 4'h2, 4'h1};
        step(5);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 16'h12AF;
        step(1);
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL data_ready_low got=%b exp=0", bus_a.in_ready); end
        checks++; if (en_a !== exp_en(1, LZ)) begin errors++; $display("FAIL data_slot1_en got=%b exp=%b", en_a, exp_en(1, LZ)); end
        step(9);
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL data_ready_hold got=%b exp=0", bus_a.in_ready); end
        checks++; if (nib_a !== 4'h0) begin errors++; $display("FAIL data_old_nibble got=%h exp=0", nib_a); end
        step(1);
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL data_ready_back got=%b exp=1", bus_a.in_ready); end
        checks++; if (en_a !== exp_en(3, LZ)) begin errors++; $display("FAIL data_pre_en got=%b exp=%b", en_a, exp_en(3, LZ)); end
        for (int k = 0; k < 16; k++) begin
            step(1);
            s = k / 4;
            checks++; if (nib_a !== exp_nib[s]) begin errors++; $display("FAIL data_nibble k=%0d got=%h exp=%h", k, nib_a, exp_nib[s]); end
            checks++; if (en_a !== exp_en(s, 1'b0)) begin errors++; $display("FAIL data_en k=%0d got=%b exp=%b", k, en_a, exp_en(s, 1'b0)); end
            checks++; if (blank_a !== 1'b0) begin errors++; $display("FAIL data_blank k=%0d got=%b exp=0", k, blank_a); end
        end
    endtask

    // 9876 accepted, then 5555 held on the bus while pending; it transfers after ready rises.
    task automatic test_back_to_back();
        logic [3:0] exp_nib [4];
        int s;
        exp_nib = '{4'h6, 4'h7, 4'h8, 4'h9};
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 16'h9876;
        step(1);
        bus_a.in_data  = 16'h5555;
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%b exp=0", bus_a.in_ready); end
        step(14);
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_second got=%b exp=0", bus_a.in_ready); end
        checks++; if (nib_a !== 4'h1) begin errors++; $display("FAIL b2b_old_nibble got=%h exp=1", nib_a); end
        step(1);
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got=%b exp=1", bus_a.in_ready); end
        step(1);
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b exp=0", bus_a.in_ready); end
        checks++; if (nib_a !== 4'h6) begin errors++; $display("FAIL b2b_first_nibble got=%h exp=6", nib_a); end
        for (int k = 1; k < 16; k++) begin
            step(1);
            s = k / 4;
            checks++; if (nib_a !== exp_nib[s]) begin errors++; $display("FAIL b2b_nibble k=%0d got=%h exp=%h", k, nib_a, exp_nib[s]); end
            checks++; if (bus_a.in_ready !== (k == 15)) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus_a.in_ready, (k == 15)); end
        end
        for (int k = 0; k < 16; k++) begin
            step(1);
            s = k / 4;
            checks++; if (nib_a !== 4'h5) begin errors++; $display("FAIL b2b_second_nibble k=%0d got=%h exp=5", k, nib_a); end
            checks++; if (en_a !== exp_en(s, 1'b0)) begin errors++; $display("FAIL b2b_en k=%0d got=%b exp=%b", k, en_a, exp_en(s, 1'b0)); end
        end
    endtask

    // Reset while ABCD is pending in slot 2: display restarts at slot 0 with 0, shadow dropped.
    task automatic test_reset_pending();
        logic [3:0] blk;
        int s;
        blk = LZ ? 4'b1110 : 4'b0000;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 16'hABCD;
        step(1);
        bus_a.in_valid = 1'b0;
        step(9);
        checks++; if (en_a !== 4'b1011) begin errors++; $display("FAIL rstp_slot2_en got=%b exp=1011", en_a); end
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending got=%b exp=0", bus_a.in_ready); end
        rst_a = 1'b1;
        step(1);
        checks++; if (en_a !== 4'b1111) begin errors++; $display("FAIL rstp_reset_en got=%b exp=1111", en_a); end
        checks++; if (blank_a !== 1'b1) begin errors++; $display("FAIL rstp_reset_blank got=%b exp=1", blank_a); end
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rstp_reset_ready got=%b exp=1", bus_a.in_ready); end
        rst_a = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step(1);
            s = (k / 4) % 4;
            checks++; if (nib_a !== 4'h0) begin errors++; $display("FAIL rstp_nibble k=%0d got=%h exp=0", k, nib_a); end
            checks++; if (en_a !== exp_en(s, blk[s])) begin errors++; $display("FAIL rstp_en k=%0d got=%b exp=%b", k, en_a, exp_en(s, blk[s])); end
            checks++; if (blank_a !== blk[s]) begin errors++; $display("FAIL rstp_blank k=%0d got=%b exp=%b", k, blank_a, blk[s]); end
            checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready k=%0d got=%b exp=1", k, bus_a.in_ready); end
        end
    endtask

    // Values with leading zeros: 0030 then 0000; blanking applies only when the macro is set.
    task automatic test_lz();
        logic [15:0] vals [2];
        logic [3:0]  exp_nib [2][4];
        logic [3:0]  blk [2];
        int s;
        vals    = '{16'h0030, 16'h0000};
        exp_nib = '{'{4'h0, 4'h3, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
        blk     = '{LZ ? 4'b1100 : 4'b0000, LZ ? 4'b1110 : 4'b0000};
        for (int v = 0; v < 2; v++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = vals[v];
            step(1);
            bus_a.in_valid = 1'b0;
            step(15);
            checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL lz_ready v=%0d got=%b exp=1", v, bus_a.in_ready); end
            for (int k = 0; k < 16; k++) begin
                step(1);
                s = k / 4;
                checks++; if (nib_a !== exp_nib[v][s]) begin errors++; $display("FAIL lz_nibble v=%0d k=%0d got=%h exp=%h", v, k, nib_a, exp_nib[v][s]); end
                checks++; if (en_a !== exp_en(s, blk[v][s])) begin errors++; $display("FAIL lz_en v=%0d k=%0d got=%b exp=%b", v, k, en_a, exp_en(s, blk[v][s])); end
                checks++; if (blank_a !== blk[v][s]) begin errors++; $display("FAIL lz_blank v=%0d k=%0d got=%b exp=%b", v, k, blank_a, blk[v][s]); end
            end
        end
    endtask

    // DIGITS=1, DIV=1: digit always enabled, data visible two cycles after accept.
    task automatic test_div1();
        step(1);
        checks++; if (en_b !== 1'b1) begin errors++; $display("FAIL div1_reset_en got=%b exp=1", en_b); end
        checks++; if (blank_b !== 1'b1) begin errors++; $display("FAIL div1_reset_blank got=%b exp=1", blank_b); end
        checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL div1_reset_ready got=%b exp=1", bus_b.in_ready); end
        rst_b = 1'b0;
        step(1);
        checks++; if (en_b !== 1'b0) begin errors++; $display("FAIL div1_en got=%b exp=0", en_b); end
        checks++; if (blank_b !== 1'b0) begin errors++; $display("FAIL div1_blank got=%b exp=0", blank_b); end
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 4'h7;
        step(1);
        bus_b.in_valid = 1'b0;
        checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL div1_accept_ready got=%b exp=0", bus_b.in_ready); end
        checks++; if (nib_b !== 4'h0) begin errors++; $display("FAIL div1_early1 got=%h exp=0", nib_b); end
        step(1);
        checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL div1_commit_ready got=%b exp=1", bus_b.in_ready); end
        checks++; if (nib_b !== 4'h0) begin errors++; $display("FAIL div1_early2 got=%h exp=0", nib_b); end
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 4'h3;
        step(1);
        bus_b.in_valid = 1'b0;
        checks++; if (nib_b !== 4'h7) begin errors++; $display("FAIL div1_show7 got=%h exp=7", nib_b); end
        checks++; if (en_b !== 1'b0) begin errors++; $display("FAIL div1_en_hold got=%b exp=0", en_b); end
        step(2);
        checks++; if (nib_b !== 4'h3) begin errors++; $display("FAIL div1_show3 got=%h exp=3", nib_b); end
    endtask

    initial begin
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        test_div1();
        test_reset();
        test_data();
        test_back_to_back();
        test_reset_pending();
        test_lz();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
